// File: rtl/dest_reg_scoreboard.sv
// dest_reg_scoreboard: per-register in-flight write counters that stall decode on pending source operands
// Register 0 is never pending; cnt_q[0] is held at zero so indexing by any address stays uniform.
module dest_reg_scoreboard #(
  parameter int ADDR_W    = 5,
  parameter int CNT_W     = 2,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              IssueValid,
  input  logic [ADDR_W-1:0] IssueDst,
  output logic              IssueReady,
  input  logic              WbValid,
  input  logic [ADDR_W-1:0] WbDst,
  input  logic [ADDR_W-1:0] RsAddr,
  input  logic              RsUse,
  input  logic [ADDR_W-1:0] RtAddr,
  input  logic              RtUse,
  output logic              Stall,
  output logic              WbError
);
  localparam int NUM_REGS = 2**ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  logic [CNT_W-1:0] cnt_q [NUM_REGS];
  logic [CNT_W-1:0] cnt_d [NUM_REGS];
  logic wb_error_q, wb_error_d;
  logic [CNT_W-1:0] cnt_iss, cnt_wb, cnt_rs, cnt_rt;
  logic issue_acc, wb_eff, wb_nz, hz_rs, hz_rt;
  assign cnt_iss = cnt_q[IssueDst];
  assign cnt_wb  = cnt_q[WbDst];
  assign cnt_rs  = cnt_q[RsAddr];
  assign cnt_rt  = cnt_q[RtAddr];
  assign wb_nz   = WbValid && WbDst != '0;
  assign IssueReady = !(IssueDst != '0 && cnt_iss == CNT_MAX);
  assign issue_acc  = IssueValid && IssueReady && IssueDst != '0;
  assign wb_eff     = wb_nz && cnt_wb != '0;
  // A write-back retiring the last pending write releases the stall in its own cycle.
  assign hz_rs = RsUse && RsAddr != '0 && cnt_rs != '0 &&
                 !(WB_BYPASS && WbValid && WbDst == RsAddr && cnt_rs == CNT_ONE);
  assign hz_rt = RtUse && RtAddr != '0 && cnt_rt != '0 &&
                 !(WB_BYPASS && WbValid && WbDst == RtAddr && cnt_rt == CNT_ONE);
  assign Stall   = hz_rs || hz_rt;
  assign WbError = wb_error_q;
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = (Flush || r == 0) ? '0 :
                 (issue_acc && IssueDst == ADDR_W'(r) && !(wb_eff && WbDst == ADDR_W'(r))) ? cnt_q[r] + CNT_ONE :
                 (wb_eff && WbDst == ADDR_W'(r) && !(issue_acc && IssueDst == ADDR_W'(r))) ? cnt_q[r] - CNT_ONE :
                 cnt_q[r];
    end
    wb_error_d = wb_error_q || (wb_nz && cnt_wb == '0 && !Flush);
  end
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      wb_error_q <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
      wb_error_q <= wb_error_d;
    end
  end
endmodule

// File: tb/tb_dest_reg_scoreboard.sv
// tb_dest_reg_scoreboard: directed checks of a bypassing and a non-bypassing scoreboard driven in parallel
`timescale 1ns/1ps
module tb_dest_reg_scoreboard;
  logic Clk = 1'b0, Reset, Flush, IssueValid, WbValid, RsUse, RtUse;
  logic [4:0] IssueDst, WbDst, RsAddr, RtAddr;
  logic rdy_b, stall_b, err_b, rdy_n, stall_n, err_n;
  int n_chk = 0, n_fail = 0;
  always #5 Clk = ~Clk;
  dest_reg_scoreboard #(.ADDR_W(5), .CNT_W(2), .WB_BYPASS(1'b1)) u_byp (
    .Clk(Clk), .Reset(Reset), .Flush(Flush), .IssueValid(IssueValid), .IssueDst(IssueDst),
    .IssueReady(rdy_b), .WbValid(WbValid), .WbDst(WbDst), .RsAddr(RsAddr), .RsUse(RsUse),
    .RtAddr(RtAddr), .RtUse(RtUse), .Stall(stall_b), .WbError(err_b));
  dest_reg_scoreboard #(.ADDR_W(5), .CNT_W(2), .WB_BYPASS(1'b0)) u_nob (
    .Clk(Clk), .Reset(Reset), .Flush(Flush), .IssueValid(IssueValid), .IssueDst(IssueDst),
    .IssueReady(rdy_n), .WbValid(WbValid), .WbDst(WbDst), .RsAddr(RsAddr), .RsUse(RsUse),
    .RtAddr(RtAddr), .RtUse(RtUse), .Stall(stall_n), .WbError(err_n));
  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    Flush = 0; IssueValid = 0; IssueDst = 0; WbValid = 0; WbDst = 0;
    RsAddr = 0; RsUse = 0; RtAddr = 0; RtUse = 0;
  endtask
  task automatic tick();
    @(posedge Clk); #1;
  endtask
  task automatic settle();
    #1;
  endtask
  task automatic issue(input logic [4:0] d);
    idle(); IssueValid = 1; IssueDst = d; tick();
  endtask
  task automatic wb(input logic [4:0] d);
    idle(); WbValid = 1; WbDst = d; tick();
  endtask
  initial begin
    idle(); Reset = 0;
    #2;
    chk("rst_stall_b", stall_b, 1'b0); chk("rst_stall_n", stall_n, 1'b0);
    chk("rst_ready", rdy_b, 1'b1); chk("rst_err", err_b, 1'b0);
    tick(); tick(); Reset = 1; tick();
    idle(); RsAddr = 8; RsUse = 1; RtAddr = 31; RtUse = 1; settle();
    chk("idle_stall", stall_b, 1'b0); chk("idle_ready31", rdy_b, 1'b1);
    idle(); IssueValid = 1; IssueDst = 8; RsAddr = 8; RsUse = 1; settle();
    chk("iss8_same_cycle", stall_b, 1'b0);
    tick();
    idle(); RsAddr = 8; RsUse = 1; settle();
    chk("iss8_stall_b", stall_b, 1'b1); chk("iss8_stall_n", stall_n, 1'b1);
    RsUse = 0; settle();
    chk("iss8_nouse", stall_b, 1'b0);
    WbValid = 1; WbDst = 8; RsUse = 1; settle();
    chk("wb8_byp", stall_b, 1'b0); chk("wb8_nobyp", stall_n, 1'b1);
    tick();
    idle(); RsAddr = 8; RsUse = 1; settle();
    chk("wb8_after_b", stall_b, 1'b0); chk("wb8_after_n", stall_n, 1'b0); chk("wb8_err", err_b, 1'b0);
    issue(5); issue(5);
    idle(); IssueValid = 1; IssueDst = 5; settle();
    chk("r5_ready_at2", rdy_b, 1'b1);
    tick();
    idle(); IssueValid = 1; IssueDst = 5; settle();
    chk("r5_full_b", rdy_b, 1'b0); chk("r5_full_n", rdy_n, 1'b0);
    IssueDst = 6; settle();
    chk("r6_ready", rdy_b, 1'b1);
    IssueDst = 5; tick();
    idle(); RtAddr = 5; RtUse = 1; settle();
    chk("r5_stall_rt", stall_b, 1'b1);
    wb(5);
    idle(); IssueDst = 5; RtAddr = 5; RtUse = 1; settle();
    chk("r5_ready_after_wb", rdy_b, 1'b1); chk("r5_still_pend", stall_b, 1'b1);
    wb(5);
    idle(); WbValid = 1; WbDst = 5; RtAddr = 5; RtUse = 1; settle();
    chk("r5_last_wb_b", stall_b, 1'b0); chk("r5_last_wb_n", stall_n, 1'b1);
    tick();
    idle(); RtAddr = 5; RtUse = 1; settle();
    chk("r5_clear_b", stall_b, 1'b0); chk("r5_clear_n", stall_n, 1'b0); chk("r5_err", err_b, 1'b0);
    idle(); IssueValid = 1; IssueDst = 0; RsAddr = 0; RsUse = 1; settle();
    chk("r0_ready", rdy_b, 1'b1); chk("r0_stall", stall_b, 1'b0);
    tick();
    idle(); RsAddr = 0; RsUse = 1; settle();
    chk("r0_after", stall_b, 1'b0);
    wb(0);
    chk("r0_wb_no_err", err_b, 1'b0);
    wb(9);
    idle(); settle();
    chk("err_set_b", err_b, 1'b1); chk("err_set_n", err_n, 1'b1);
    tick(); tick();
    chk("err_sticky", err_b, 1'b1);
    issue(3);
    idle(); IssueValid = 1; IssueDst = 3; WbValid = 1; WbDst = 3; tick();
    idle(); RsAddr = 3; RsUse = 1; settle();
    chk("r3_kept", stall_b, 1'b1);
    WbValid = 1; WbDst = 3; settle();
    chk("r3_one_b", stall_b, 1'b0); chk("r3_one_n", stall_n, 1'b1);
    tick();
    idle(); RsAddr = 3; RsUse = 1; settle();
    chk("r3_clear", stall_n, 1'b0);
    issue(6);
    idle(); Flush = 1; IssueValid = 1; IssueDst = 4; tick();
    idle(); RsAddr = 4; RsUse = 1; RtAddr = 6; RtUse = 1; settle();
    chk("flush_b", stall_b, 1'b0); chk("flush_n", stall_n, 1'b0);
    issue(7);
    idle(); RsAddr = 7; RsUse = 1; settle();
    chk("r7_stall", stall_b, 1'b1);
    #1 Reset = 0; #1;
    chk("arst_stall", stall_b, 1'b0); chk("arst_err", err_b, 1'b0); chk("arst_err_n", err_n, 1'b0);
    tick(); Reset = 1; tick();
    chk("post_rst_stall", stall_n, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
